// File: rtl/pc_next_unit_pkg.sv
// Shared types for the next-PC stage: ALU opcode encoding and PC sequencer states.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_XOR     = 3'd0,
        OP_SHIFT   = 3'd1,
        OP_MEM     = 3'd2,
        OP_BNEQ    = 3'd3,
        OP_HALFSET = 3'd4,
        OP_AND     = 3'd5,
        OP_BLT     = 3'd6,
        OP_NOP     = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    function automatic logic branch_taken(alu_op_e cmd, logic notequal, logic lessthan);
        return ((cmd == OP_BNEQ) && notequal) || ((cmd == OP_BLT) && lessthan);
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/branch/LUT-write bundle between decoder/bench and the next-PC stage.
// PC_PERF_CNT_EN adds the cyc_cnt/br_cnt performance counter outputs.
interface pc_next_unit_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
);
    import cpu_pkg::*;

    logic              start;
    logic              stall;
    alu_op_e           alu_cmd;
    logic              notequal;
    logic              lessthan;
    logic [LUT_AW-1:0] br_idx;
    logic              halt_req;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic              br_taken;
`ifdef PC_PERF_CNT_EN
    logic [15:0]       cyc_cnt;
    logic [15:0]       br_cnt;
`endif

    modport master (
        output start, stall, alu_cmd, notequal, lessthan, br_idx, halt_req,
               lut_we, lut_waddr, lut_wdata,
`ifdef PC_PERF_CNT_EN
        input  cyc_cnt, br_cnt,
`endif
        input  pc, running, done, br_taken
    );

    modport slave (
        input  start, stall, alu_cmd, notequal, lessthan, br_idx, halt_req,
               lut_we, lut_waddr, lut_wdata,
`ifdef PC_PERF_CNT_EN
        output cyc_cnt, br_cnt,
`endif
        output pc, running, done, br_taken
    );

endinterface

// File: rtl/pc_next_unit_branch_lut.sv
// Branch-target register file: async read, sync write, async clear.
module pc_branch_lut #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);
    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic [PC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read sees the pre-edge contents, giving read-before-write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC stage: PC register, IDLE/RUN/HALT sequencer, branch redirect via target LUT.
// PC_PERF_CNT_EN adds saturating RUN-cycle and taken-branch counters.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
) (
    input logic             clk,
    input logic             rst_n,
    pc_next_unit_if.slave   bus
);
    localparam logic [PC_W-1:0] PC_MAX = '1;

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            br_taken_q, br_taken_d;
    logic            enter_run;
    logic            take_fire;
    logic [PC_W-1:0] lut_rdata;

    pc_branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (bus.br_idx),
        .rdata (lut_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            br_taken_q <= br_taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        br_taken_d = 1'b0;
        enter_run  = 1'b0;
        take_fire  = 1'b0;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else if (branch_taken(bus.alu_cmd, bus.notequal, bus.lessthan)) begin
                    pc_d       = lut_rdata;
                    br_taken_d = 1'b1;
                    take_fire  = 1'b1;
                end else if (pc_q == PC_MAX) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = (state_q == HALT);
    assign bus.br_taken = br_taken_q;

`ifdef PC_PERF_CNT_EN
    logic [15:0] cyc_cnt_q, br_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else if (enter_run) begin
            cyc_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else begin
            if (state_q == RUN && cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 16'd1;
            if (take_fire && br_cnt_q != '1)       br_cnt_q  <= br_cnt_q + 16'd1;
        end
    end

    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.br_cnt  = br_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a per-cycle reference model.
module tb_pc_next_unit;
    import cpu_pkg::*;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;
    localparam int PC_MAX = (1 << PC_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_next_unit_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

    pc_next_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: architectural view (running/done flags, integer PC, LUT array).
    int m_pc, m_lut[16], m_cyc, m_brc;
    bit m_running, m_done, m_br, m_take, m_was_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_running = 0; m_done = 0; m_br = 0; m_cyc = 0; m_brc = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            m_take    = ((bus.alu_cmd == OP_BNEQ) && bus.notequal) ||
                        ((bus.alu_cmd == OP_BLT) && bus.lessthan);
            m_was_run = m_running;
            m_br      = 0;
            if (m_running) begin
                if (m_cyc < 65535) m_cyc++;
                if (bus.stall) begin
                end else if (bus.halt_req) begin
                    m_running = 0; m_done = 1;
                end else if (m_take) begin
                    m_pc = m_lut[bus.br_idx]; m_br = 1;
                    if (m_brc < 65535) m_brc++;
                end else if (m_pc == PC_MAX) begin
                    m_running = 0; m_done = 1;
                end else begin
                    m_pc = m_pc + 1;
                end
            end else if (bus.start) begin
                m_running = 1; m_done = 0; m_pc = 0; m_cyc = 0; m_brc = 0;
            end
            if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
        end
    end

    always @(negedge clk) begin
        chk("pc", int'(bus.pc), m_pc);
        chk("running", int'(bus.running), int'(m_running));
        chk("done", int'(bus.done), int'(m_done));
        chk("br_taken", int'(bus.br_taken), int'(m_br));
`ifdef PC_PERF_CNT_EN
        chk("cyc_cnt", int'(bus.cyc_cnt), m_cyc);
        chk("br_cnt", int'(bus.br_cnt), m_brc);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.stall = 0; bus.alu_cmd = OP_NOP; bus.notequal = 0;
        bus.lessthan = 0; bus.br_idx = '0; bus.halt_req = 0;
        bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    endtask

    task automatic lut_write(input int a, input int d);
        bus.lut_we = 1; bus.lut_waddr = LUT_AW'(a); bus.lut_wdata = PC_W'(d);
        step();
        bus.lut_we = 0;
    endtask

    task automatic start_run();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    task automatic branch(input alu_op_e op, input bit ne, input bit lt, input int idx);
        bus.alu_cmd = op; bus.notequal = ne; bus.lessthan = lt; bus.br_idx = LUT_AW'(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        step(); step();
        rst_n = 1;
        step();
        chk("reset_pc", int'(bus.pc), 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_done", int'(bus.done), 0);

        // Scenario 1: async reset mid-run at pc=37, then restart counts 0,1,2
        start_run();
        chk("s1_start_pc", int'(bus.pc), 0);
        for (int i = 0; i < 100 && bus.pc != 37; i++) step();
        chk("s1_reached_37", int'(bus.pc), 37);
        rst_n = 0;
        #1;
        chk("s1_async_pc", int'(bus.pc), 0);
        chk("s1_async_running", int'(bus.running), 0);
        chk("s1_async_done", int'(bus.done), 0);
        #1 rst_n = 1;
        step();
        chk("s1_idle_hold", int'(bus.running), 0);
        start_run();
        chk("s1_pc0", int'(bus.pc), 0);
        step();
        chk("s1_pc1", int'(bus.pc), 1);
        step();
        chk("s1_pc2", int'(bus.pc), 2);

        // Scenario 2: taken BNEQ via lut[5]=200 (LUT writable while running)
        lut_write(5, 200);
        lut_write(2, 12);
        lut_write(3, 40);
        lut_write(7, 1020);
        branch(OP_BNEQ, 1, 0, 5);
        step();
        chk("s2_pc", int'(bus.pc), 200);
        chk("s2_br_taken", int'(bus.br_taken), 1);
        branch(OP_NOP, 0, 0, 0);
        step();
        chk("s2_pc_next", int'(bus.pc), 201);
        chk("s2_br_pulse_end", int'(bus.br_taken), 0);

        // Scenario 3: not-taken branches fall through to pc+1
        branch(OP_BNEQ, 1, 0, 2);
        step();
        chk("s3_pc12", int'(bus.pc), 12);
        branch(OP_BLT, 1, 0, 5);
        step();
        chk("s3_blt_nt", int'(bus.pc), 13);
        chk("s3_blt_nt_br", int'(bus.br_taken), 0);
        branch(OP_BNEQ, 0, 1, 5);
        step();
        chk("s3_bneq_nt", int'(bus.pc), 14);
        branch(OP_BLT, 0, 1, 2);
        step();
        chk("s3_blt_taken", int'(bus.pc), 12);

        // Scenario 4: stall masks branch and halt
        branch(OP_BNEQ, 1, 0, 5);
        bus.stall = 1; bus.halt_req = 1;
        step();
        chk("s4_stall_pc", int'(bus.pc), 12);
        chk("s4_stall_running", int'(bus.running), 1);
        chk("s4_stall_br", int'(bus.br_taken), 0);
        bus.stall = 0; bus.halt_req = 0;
        step();
        chk("s4_release_pc", int'(bus.pc), 200);
        chk("s4_release_br", int'(bus.br_taken), 1);

        // Scenario 6: same-edge write and branch read of entry 3
        branch(OP_BNEQ, 1, 0, 3);
        bus.lut_we = 1; bus.lut_waddr = 4'd3; bus.lut_wdata = 10'd99;
        step();
        bus.lut_we = 0;
        chk("s6_old_entry", int'(bus.pc), 40);
        branch(OP_NOP, 0, 0, 0);
        step();
        chk("s6_pc41", int'(bus.pc), 41);
        branch(OP_BLT, 0, 1, 3);
        step();
        chk("s6_new_entry", int'(bus.pc), 99);

        // Scenario 5: run off the end of the PC space into HALT
        branch(OP_BNEQ, 1, 0, 7);
        step();
        chk("s5_pc1020", int'(bus.pc), 1020);
        branch(OP_NOP, 0, 0, 0);
        bus.start = 1;
        step(); step(); step();
        chk("s5_pc_max", int'(bus.pc), PC_MAX);
        chk("s5_still_running", int'(bus.running), 1);
        bus.start = 0;
        step();
        chk("s5_halt_pc", int'(bus.pc), PC_MAX);
        chk("s5_done", int'(bus.done), 1);
        chk("s5_halt_running", int'(bus.running), 0);
        step();
        chk("s5_done_held", int'(bus.done), 1);
        start_run();
        chk("s5_restart_pc", int'(bus.pc), 0);
        chk("s5_restart_done", int'(bus.done), 0);

        // halt_req: HALT with pc pointing at the halt instruction
        step(); step();
        bus.halt_req = 1;
        step();
        bus.halt_req = 0;
        chk("halt_pc", int'(bus.pc), 2);
        chk("halt_done", int'(bus.done), 1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
